// File: rtl/pipeline_job_driver_pkg.sv
// Shared definitions for the pipeline job driver: FSM encoding, bus widths
// and the split of the pipeline response word into its two result fields.
package pipeline_job_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_TOP = 3'd1,
        ST_STREAM   = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam int BOT_WIDTH          = 128;
    localparam int HALF_BOT_WIDTH     = 64;
    localparam int RESP_WIDTH         = 64;
    localparam int COUNT_WIDTH        = 32;
    localparam int SUM_FIELD_WIDTH    = 48;
    localparam int PCOEFF_FIELD_LSB   = 48;
    localparam int PCOEFF_FIELD_WIDTH = 16;

    // Low part of a response word: the partial summedData contribution.
    function automatic logic [SUM_FIELD_WIDTH-1:0] resp_sum_field(input logic [RESP_WIDTH-1:0] resp);
        return resp[SUM_FIELD_WIDTH-1:0];
    endfunction

    // High part of a response word: the partial pcoeffCount contribution.
    function automatic logic [PCOEFF_FIELD_WIDTH-1:0] resp_pcoeff_field(input logic [RESP_WIDTH-1:0] resp);
        return resp[PCOEFF_FIELD_LSB +: PCOEFF_FIELD_WIDTH];
    endfunction

endpackage

// File: rtl/pipeline_job_driver_result_accumulator.sv
// Counts received pipeline responses and accumulates their two fields.
// Both accumulators wrap naturally at their register width.
module pipeline_job_driver_result_accumulator
    import pipeline_job_driver_pkg::*;
#(
    parameter int SUM_WIDTH    = 64,
    parameter int PCOEFF_WIDTH = 40
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [RESP_WIDTH-1:0]   resp,
    output logic [COUNT_WIDTH-1:0]  recv_count,
    output logic [SUM_WIDTH-1:0]    sum,
    output logic [PCOEFF_WIDTH-1:0] pcoeff
);

    logic [COUNT_WIDTH-1:0]  recv_count_r;
    logic [SUM_WIDTH-1:0]    sum_r;
    logic [PCOEFF_WIDTH-1:0] pcoeff_r;

    // Clear on reset or job start; otherwise add each absorbed response.
    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            recv_count_r <= {COUNT_WIDTH{1'b0}};
            sum_r        <= {SUM_WIDTH{1'b0}};
            pcoeff_r     <= {PCOEFF_WIDTH{1'b0}};
        end else if (enable) begin
            recv_count_r <= recv_count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            sum_r        <= sum_r + SUM_WIDTH'(resp_sum_field(resp));
            pcoeff_r     <= pcoeff_r + PCOEFF_WIDTH'(resp_pcoeff_field(resp));
        end else begin
            recv_count_r <= recv_count_r;
            sum_r        <= sum_r;
            pcoeff_r     <= pcoeff_r;
        end
    end

    assign recv_count = recv_count_r;
    assign sum        = sum_r;
    assign pcoeff     = pcoeff_r;

endmodule

// File: rtl/pipeline_job_driver.sv
// Drives one job through a non-stalling compute pipeline: loads the top,
// streams the job's bots under pipeline back-pressure, drains the responses
// into the result accumulator and presents the final sums.
module pipeline_job_driver
    import pipeline_job_driver_pkg::*;
#(
    parameter int SUM_WIDTH    = 64,
    parameter int PCOEFF_WIDTH = 40
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      jobValid,
    output logic                      jobReady,
    input  logic [BOT_WIDTH-1:0]      jobTop,
    input  logic [COUNT_WIDTH-1:0]    jobBotCount,
    input  logic                      botInValid,
    output logic                      botInReady,
    input  logic [BOT_WIDTH-1:0]      botIn,
    output logic                      startNewTop,
    output logic [HALF_BOT_WIDTH-1:0] botLower,
    output logic [HALF_BOT_WIDTH-1:0] botUpper,
    output logic                      ivalid,
    input  logic                      oready,
    input  logic                      ovalid,
    input  logic [RESP_WIDTH-1:0]     summedDataPcoeffCountOut,
    output logic                      resultValid,
    input  logic                      resultReady,
    output logic [SUM_WIDTH-1:0]      resultSum,
    output logic [PCOEFF_WIDTH-1:0]   resultPcoeff,
    output logic                      strayResult
);

    state_t                 state_r;
    state_t                 state_s;
    logic [BOT_WIDTH-1:0]   top_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic [COUNT_WIDTH-1:0] sent_r;
    logic                   stray_r;
    logic [COUNT_WIDTH-1:0] recv_count_s;
    logic [BOT_WIDTH-1:0]   bot_s;
    logic                   accept_s;
    logic                   xfer_s;
    logic                   acc_en_s;
    logic                   stray_set_s;

    // State register; reset abandons any job in flight.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Job descriptor capture and count of bots issued to the pipeline.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            top_r   <= {BOT_WIDTH{1'b0}};
            count_r <= {COUNT_WIDTH{1'b0}};
            sent_r  <= {COUNT_WIDTH{1'b0}};
        end else if (accept_s) begin
            top_r   <= jobTop;
            count_r <= jobBotCount;
            sent_r  <= {COUNT_WIDTH{1'b0}};
        end else if (xfer_s) begin
            sent_r  <= sent_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            sent_r  <= sent_r;
        end
    end

    // Sticky flag for responses that do not belong to the current job.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            stray_r <= 1'b0;
        end else if (stray_set_s) begin
            stray_r <= 1'b1;
        end else begin
            stray_r <= stray_r;
        end
    end

    // Next-state, handshake and pipeline-input decode.
    always_comb begin
        state_s     = state_r;
        jobReady    = 1'b0;
        startNewTop = 1'b0;
        ivalid      = 1'b0;
        botInReady  = 1'b0;
        resultValid = 1'b0;
        bot_s       = {BOT_WIDTH{1'b0}};
        accept_s    = 1'b0;
        xfer_s      = 1'b0;
        acc_en_s    = 1'b0;
        stray_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                jobReady    = 1'b1;
                stray_set_s = ovalid;
                if (jobValid) begin
                    accept_s = 1'b1;
                    state_s  = ST_LOAD_TOP;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_LOAD_TOP: begin
                startNewTop = 1'b1;
                bot_s       = top_r;
                acc_en_s    = ovalid;
                if (count_r != {COUNT_WIDTH{1'b0}}) begin
                    state_s = ST_STREAM;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_STREAM: begin
                // Only entered with sent_r < count_r, so ivalid cannot overshoot.
                botInReady  = oready;
                ivalid      = botInValid && oready;
                bot_s       = botIn;
                xfer_s      = ivalid;
                acc_en_s    = ovalid;
                stray_set_s = ovalid && (recv_count_s >= sent_r);
                if (xfer_s && ((sent_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1}) == count_r)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                acc_en_s = ovalid;
                if (recv_count_s == count_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                resultValid = 1'b1;
                stray_set_s = ovalid;
                if (resultReady) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign botUpper    = bot_s[BOT_WIDTH-1:HALF_BOT_WIDTH];
    assign botLower    = bot_s[HALF_BOT_WIDTH-1:0];
    assign strayResult = stray_r;

    pipeline_job_driver_result_accumulator #(
        .SUM_WIDTH   (SUM_WIDTH),
        .PCOEFF_WIDTH(PCOEFF_WIDTH)
    ) u_result_accumulator (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (accept_s),
        .enable    (acc_en_s),
        .resp      (summedDataPcoeffCountOut),
        .recv_count(recv_count_s),
        .sum       (resultSum),
        .pcoeff    (resultPcoeff)
    );

endmodule

// File: doc/pipeline_job_driver.md
PIPELINE_JOB_DRIVER -- requirements
Module: pipeline_job_driver

Interface
REQ-001 SHALL have parameter SUM_WIDTH, default 64, meaning the width of the summedData accumulator.
REQ-002 SHALL have parameter PCOEFF_WIDTH, default 40, meaning the width of the pcoeffCount accumulator.
REQ-003 SHALL use one clock and a synchronous, active-low reset, with ports named clock and resetn.
REQ-004 clock  in  1  sole clock.
REQ-005 resetn  in  1  synchronous active-low reset.
REQ-006 jobValid  in  1; jobReady  out  1  job handshake.
REQ-007 jobTop  in  128  top for the job.
REQ-008 jobBotCount  in  32  number of bots in the job.
REQ-009 botInValid  in  1; botInReady  out  1; botIn  in  128  bot source stream.
REQ-010 startNewTop  out  1; botLower  out  64; botUpper  out  64; ivalid  out  1  drive the pipeline input.
REQ-011 oready  in  1; ovalid  in  1; summedDataPcoeffCountOut  in  64  pipeline response.
REQ-012 resultValid  out  1; resultReady  in  1; resultSum  out  SUM_WIDTH; resultPcoeff  out  PCOEFF_WIDTH  job result.
REQ-013 strayResult  out  1  sticky error flag.

Function
REQ-014 SHALL implement states IDLE, LOAD_TOP, STREAM, DRAIN and DONE.
REQ-015 IDLE: jobReady=1; on jobValid, SHALL latch jobTop and jobBotCount, clear counters and accumulators, and go to LOAD_TOP.
REQ-016 LOAD_TOP: exactly one cycle with startNewTop=1, ivalid=0 and {botUpper,botLower}=latched top; next state is STREAM if count>0, otherwise DONE.
REQ-017 STREAM: botInReady=oready; ivalid=botInValid&&oready; {botUpper,botLower}=botIn; each transfer increments sentCount.
REQ-018 STREAM SHALL go to DRAIN on the transfer that makes sentCount==count; ivalid SHALL never exceed count.
REQ-019 ivalid, startNewTop and botInReady SHALL be 0 in all states except those stated above.
REQ-020 The pipeline output does not stall, so every ovalid cycle SHALL be absorbed in the same cycle.
REQ-021 In LOAD_TOP, STREAM or DRAIN, each ovalid SHALL increment recvCount.
REQ-022 On each such ovalid, the block SHALL add zero-extended bits[47:0] to resultSum and bits[63:48] to resultPcoeff.
REQ-023 Both accumulators SHALL wrap modulo 2^width.
REQ-024 Any ovalid in IDLE or DONE SHALL set strayResult and SHALL NOT alter the accumulators; strayResult is cleared only by reset.
REQ-025 An ovalid in STREAM that would make recvCount exceed sentCount SHALL also set strayResult.
REQ-026 DRAIN SHALL go to DONE in the cycle after recvCount==count, including an ovalid on the final sending cycle.
REQ-027 DONE: resultValid=1 with stable resultSum and resultPcoeff; on resultReady, SHALL go to IDLE.
REQ-028 resultValid and jobReady SHALL never be 1 in the same cycle.
REQ-029 Latency: job accepted at cycle N, startNewTop at N+1, first possible ivalid at N+2.
REQ-030 For a zero-bot job, resultValid SHALL assert at N+2 with both sums 0.
REQ-031 A simultaneous final ovalid and state change SHALL still count that result.

Reset
REQ-032 While resetn=0 at a clock edge, state SHALL go to IDLE.
REQ-033 While resetn=0 at a clock edge, all counters, accumulators and strayResult SHALL be cleared.
REQ-034 While resetn=0 at a clock edge, outputs SHALL be 0 except jobReady=1 after reset.
REQ-035 Reset mid-job SHALL abandon the job without emitting a result.
REQ-036 After reset, ovalid from in-flight bots SHALL be treated as stray (REQ-024).

Structure
REQ-037 State encoding, the 48/16 result field split, and the 128-bit bot width SHALL be placed in the shared pipelineGlobals.vh include.
REQ-038 One sub-module SHALL be used: result_accumulator (recvCount plus both accumulators, with clear and enable); the FSM and issue logic SHALL stay in the top.

Verification
REQ-039 Reset, then a job with count=3, oready=1, ovalid returning 0x0001_0000_0000_0005, 0x0002_0000_0000_0007 and 0x0000_0000_0000_0001 -> startNewTop 1 cycle, 3 ivalid pulses, resultSum=13, resultPcoeff=3.
REQ-040 Job with count=0 -> startNewTop pulse, no ivalid, resultValid at N+2 with sums 0.
REQ-041 count=4 with oready toggled 1,0,0,1,1,0,1 -> exactly 4 ivalid, none while oready=0, botInReady mirrors oready.
REQ-042 ovalid pulse in IDLE -> strayResult=1 and the next job's sums are unaffected.
REQ-043 resultReady held 0 for 5 cycles in DONE -> result stable and jobReady=0 throughout; released -> IDLE.
REQ-044 resetn=0 during STREAM of a count=10 job -> IDLE next cycle, jobReady=1, no resultValid; the next job sums correctly.
